mul_sched: RTL and testbench
============================

Name: mul_sched

Overview:
- Sequencer and arbiter that shares one iterative 32x32 shift-add multiplier (`mul`) between NREQ requesters, such as ALU issue ports and the address-generation unit.
- Accepts requests through a valid/ready handshake and arbitrates round-robin.
- Per job: clears the multiplier, holds its operands stable, waits for drdy, captures the selected 32-bit result half, and returns it tagged with the requester id.
- Sits between the execute-stage requesters and the `mul` instance.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 40, maximum RUN cycles before the job is aborted with an error.
- IDW, derived (clog2 of NREQ, minimum 1), requester id width; localparam, not overridable.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set.
- req_a  in  NREQ*32  operand A, packed; requester i uses bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, packed the same way.
- req_signed  in  NREQ  1 = two's complement, 0 = unsigned.
- req_upper  in  NREQ  1 = return product bits [63:32], 0 = bits [31:0].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_data  out  32  result half.
- rsp_err  out  1  job hit TIMEOUT; rsp_data is 0.
- busy  out  1  state is not IDLE.
- mul_a  out  32  drives multiplier A.
- mul_b  out  32  drives multiplier B.
- mul_rst  out  1  drives multiplier rst.
- mul_signctl  out  1  drives multiplier signctl.
- mul_upper  out  1  drives multiplier upper.
- mul_dout  in  32  multiplier result.
- mul_drdy  in  1  multiplier done.

Behaviour:
- Reset:
  - state = IDLE; round-robin pointer = 0.
  - rsp_valid, rsp_err, rsp_data, rsp_id, busy, req_ready, mul_a, mul_b, mul_signctl, mul_upper all 0.
  - mul_rst = rst OR (state == CLEAR), so the multiplier is also cleared during rst.
  - rst mid-job discards the job with no response; rst overrides every other input.
- IDLE:
  - Grant the first valid requester found searching upward from the pointer, with wrap.
  - req_ready[grant] = 1, combinational, in IDLE only.
  - On valid & ready: latch A, B, signed, upper and id; go to CLEAR.
  - A requester dropping valid before acceptance has no effect.
- CLEAR (1 cycle):
  - mul_rst = 1.
  - mul_a, mul_b, mul_signctl and mul_upper come from the latched registers from CLEAR until leaving RUN, and are held stable throughout.
- RUN:
  - Cycle counter starts at 0.
  - mul_drdy is ignored in RUN cycle 0 (settle cycle after clear).
  - From cycle 1 on, when mul_drdy = 1: rsp_data <= mul_dout, rsp_err <= 0, go to RESP.
  - When the counter reaches TIMEOUT with no drdy: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - When drdy and the timeout coincide, drdy wins.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_ready: pointer <= (id + 1) mod NREQ, go to IDLE.
  - No new request is accepted in the same cycle.
- Latency:
  - Accept edge = cycle 0. CLEAR is cycle 1; earliest RUN sample is cycle 3; earliest rsp_valid is cycle 4.
  - Worst case rsp_valid is cycle TIMEOUT+3.
  - Back-to-back jobs are separated by at least one IDLE cycle.
- Fairness: with all requesters valid continuously, grants rotate 0,1,..,NREQ-1,0.

Optional Feature:
- Macro MUL_SCHED_ZERO_BYPASS_EN.
- Defined: when a latched A or B equals 0, the block goes IDLE -> RESP directly with rsp_data = 0 and rsp_err = 0.
  - No mul_rst pulse and no multiplier activity.
  - rsp_valid asserts in cycle 1.
- Undefined: every job runs through CLEAR and RUN, with timing as above.

Decomposition:
- Package mul_sched_pkg holds:
  - state enum {IDLE, CLEAR, RUN, RESP};
  - DATA_W = 32;
  - the default TIMEOUT constant.
- Sub-module rr_arb: a parameterised NREQ round-robin priority picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register stays in mul_sched.

Test Plan:
- The bench uses a behavioural multiplier model (configurable drdy delay, default 33 cycles).
- Req0: A=7, B=6, unsigned, upper=0 -> rsp_id=0, rsp_data=42, rsp_err=0; mul_a and mul_b stable from CLEAR to RESP.
- Req0 and req1 held valid continuously from reset for 4 jobs -> grant order 0,1,0,1; req_ready never has 2 bits set.
- Req1: A=0x80000000, B=2, unsigned, upper=1 -> rsp_data=0x00000001, rsp_id=1.
- Model drdy held low, TIMEOUT=40 -> rsp_err=1, rsp_data=0, rsp_valid at cycle 43 after accept.
- rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; IDLE one cycle after the handshake.
- rst pulsed in RUN cycle 10 -> mul_rst=1 that cycle, no response, busy=0 next cycle; next request completes correctly.
- With MUL_SCHED_ZERO_BYPASS_EN: B=0 -> rsp_data=0 at cycle 1, mul_rst never pulses.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared types and constants for the multiplier scheduler.
//   state_t     - sequencer states
//   DATA_W      - operand / result width
//   TIMEOUT_DEF - default RUN-cycle budget before a job is aborted
package mul_sched_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned TIMEOUT_DEF = 40;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/mul_sched_rr_arb.sv
// rr_arb: combinational round-robin picker.
//   i_req  - request vector
//   i_ptr  - highest-priority index
//   o_gnt  - one-hot grant (zero when no request)
//   o_idx  - encoded grant index
//   o_any  - at least one request present
module rr_arb #(
   parameter int unsigned  NREQ = 2,
   localparam int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
)(
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   logic [2*NREQ-1:0] w_rot;
   logic [IDW-1:0]    w_off;
   logic [IDW:0]      w_sum;

   // Rotate so the pointer position lands at bit 0; doubling handles the wrap.
   assign w_rot = {i_req, i_req} >> i_ptr;

   // Lowest set bit of the rotated vector is the winner's offset from the pointer.
   always_comb begin
      w_off = '0;
      o_any = 1'b0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = IDW'(k);
            o_any = 1'b1;
         end
      end
   end

   // Pointer + offset, reduced modulo NREQ (NREQ need not be a power of two).
   assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
   assign o_idx = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : IDW'(w_sum);

   always_comb begin
      o_gnt = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         o_gnt[i] = o_any && (o_idx == IDW'(i));
      end
   end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: shares one iterative 32x32 multiplier between NREQ requesters.
// Round-robin accept (valid/ready), clear the multiplier, hold operands,
// wait for drdy (or TIMEOUT), return the selected product half with the id.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req_valid/ready/a/b/signed/upper - packed per-requester request channel
//   rsp_valid/ready/id/data/err      - response channel
//   busy                             - not IDLE
//   mul_a/b/rst/signctl/upper        - multiplier controls
//   mul_dout, mul_drdy               - multiplier result / done
// Optional: define MUL_SCHED_ZERO_BYPASS_EN to answer jobs with a zero
// operand directly (IDLE -> RESP) without touching the multiplier.
module mul_sched
   import mul_sched_pkg::*;
#(
   parameter int unsigned  NREQ    = 2,
   parameter int unsigned  TIMEOUT = TIMEOUT_DEF,
   localparam int unsigned IDW     = (NREQ > 2) ? $clog2(NREQ) : 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*DATA_W-1:0] req_a,
   input  logic [NREQ*DATA_W-1:0] req_b,
   input  logic [NREQ-1:0]        req_signed,
   input  logic [NREQ-1:0]        req_upper,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [DATA_W-1:0]      rsp_data,
   output logic                   rsp_err,
   output logic                   busy,
   output logic [DATA_W-1:0]      mul_a,
   output logic [DATA_W-1:0]      mul_b,
   output logic                   mul_rst,
   output logic                   mul_signctl,
   output logic                   mul_upper,
   input  logic [DATA_W-1:0]      mul_dout,
   input  logic                   mul_drdy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_t              r_state, w_state_nxt;
   logic [IDW-1:0]      r_ptr, r_id;
   logic [DATA_W-1:0]   r_a, r_b, r_rsp_data;
   logic                r_signed, r_upper, r_rsp_err;
   logic [CNT_W-1:0]    r_cnt;

   logic [NREQ-1:0]     w_gnt;
   logic [IDW-1:0]      w_idx;
   logic                w_any, w_accept, w_hit_drdy, w_hit_to;
   logic [DATA_W-1:0]   w_sel_a, w_sel_b;
   logic                w_sel_signed, w_sel_upper;

   rr_arb #(.NREQ(NREQ)) u_arb (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Operand mux for the granted requester.
   always_comb begin
      w_sel_a      = '0;
      w_sel_b      = '0;
      w_sel_signed = 1'b0;
      w_sel_upper  = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_idx == IDW'(i)) begin
            w_sel_a      = req_a[i*DATA_W +: DATA_W];
            w_sel_b      = req_b[i*DATA_W +: DATA_W];
            w_sel_signed = req_signed[i];
            w_sel_upper  = req_upper[i];
         end
      end
   end

   // drdy is meaningless in RUN cycle 0 (multiplier still settling from clear).
   assign w_hit_drdy = (r_cnt != '0) && mul_drdy;
   assign w_hit_to   = (r_cnt == CNT_W'(TIMEOUT));
   assign w_accept   = (r_state == IDLE) && w_any;

`ifdef MUL_SCHED_ZERO_BYPASS_EN
   logic w_zero;
   assign w_zero = (w_sel_a == '0) || (w_sel_b == '0);
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = CLEAR;
`ifdef MUL_SCHED_ZERO_BYPASS_EN
               if (w_zero) w_state_nxt = RESP;
`endif
            end
         end
         CLEAR: w_state_nxt = RUN;
         RUN:   if (w_hit_drdy || w_hit_to) w_state_nxt = RESP;
         RESP:  if (rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Job datapath: operand latch, RUN counter, result capture, RR pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= '0;
         r_id       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_signed   <= 1'b0;
         r_upper    <= 1'b0;
         r_cnt      <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a        <= w_sel_a;
                  r_b        <= w_sel_b;
                  r_signed   <= w_sel_signed;
                  r_upper    <= w_sel_upper;
                  r_id       <= w_idx;
                  r_cnt      <= '0;
                  // Zero here doubles as the bypass result.
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b0;
               end
            end
            RUN: begin
               if (w_hit_drdy) begin
                  r_rsp_data <= mul_dout;
                  r_rsp_err  <= 1'b0;
               end else if (w_hit_to) begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready   = (r_state == IDLE) ? w_gnt : '0;
   assign rsp_valid   = (r_state == RESP);
   assign rsp_id      = r_id;
   assign rsp_data    = r_rsp_data;
   assign rsp_err     = r_rsp_err;
   assign busy        = (r_state != IDLE);
   assign mul_a       = r_a;
   assign mul_b       = r_b;
   assign mul_signctl = r_signed;
   assign mul_upper   = r_upper;
   assign mul_rst     = rst || (r_state == CLEAR);

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural iterative multiplier.
module tb_mul_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a, req_b;
   logic [1:0]  req_signed, req_upper;
   logic        rsp_valid, rsp_ready;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_err, busy;
   logic [31:0] mul_a, mul_b, mul_dout;
   logic        mul_rst, mul_signctl, mul_upper, mul_drdy;

   int n_vec = 0;
   int n_err = 0;

   // Multiplier model: drdy m_delay cycles after the clear, unless held low.
   int          m_delay   = 33;
   logic        m_hold_low = 1'b0;
   logic [7:0]  m_cnt = 8'd0;
   logic [63:0] m_prod;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (mul_rst)               m_cnt <= 8'd0;
      else if (m_cnt != 8'hFF)   m_cnt <= m_cnt + 8'd1;
   end

   always_comb begin
      if (mul_signctl)
         m_prod = 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}));
      else
         m_prod = {32'd0, mul_a} * {32'd0, mul_b};
   end
   assign mul_dout = mul_upper ? m_prod[63:32] : m_prod[31:0];
   assign mul_drdy = !m_hold_low && !mul_rst && (32'(m_cnt) >= m_delay);

   mul_sched #(.NREQ(2), .TIMEOUT(40)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_signed  (req_signed),
      .req_upper   (req_upper),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_rst     (mul_rst),
      .mul_signctl (mul_signctl),
      .mul_upper   (mul_upper),
      .mul_dout    (mul_dout),
      .mul_drdy    (mul_drdy)
   );

   // Present a request at the current negedge; returns at the next negedge
   // (cycle 1 after accept) with the valid dropped.
   task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic u);
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      req_signed[r]     = s;
      req_upper[r]      = u;
      req_valid[r]      = 1'b1;
      @(negedge clk);
      req_valid[r]      = 1'b0;
   endtask

   // From cycle 1, step negedges until rsp_valid or the limit; cyc = cycle index.
   task automatic wait_rsp(input int limit, output int cyc);
      cyc = 1;
      while (!rsp_valid && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({busy, rsp_valid, rsp_err, req_ready, mul_rst} !== 6'b000001) begin
         n_err++;
         $display("FAIL reset_ctl got busy/vld/err/rdy/mrst=%b want 000001",
                  {busy, rsp_valid, rsp_err, req_ready, mul_rst});
      end
      n_vec++;
      if ({mul_a, mul_b, rsp_data} !== 96'd0 || {mul_signctl, mul_upper, rsp_id} !== 3'd0) begin
         n_err++;
         $display("FAIL reset_data got a=%h b=%h d=%h want zeros", mul_a, mul_b, rsp_data);
      end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (mul_rst !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release mul_rst got %b want 0", mul_rst);
      end
   endtask

   task automatic test_basic();
      int cyc;
      logic stable;
      req_valid = 2'b01;
      req_a[31:0] = 32'd7; req_b[31:0] = 32'd6; req_signed[0] = 1'b0; req_upper[0] = 1'b0;
      #1;
      n_vec++;
      if (req_ready !== 2'b01) begin
         n_err++;
         $display("FAIL basic_ready got %b want 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      n_vec++;
      if (!(mul_rst === 1'b1 && mul_a === 32'd7 && mul_b === 32'd6 && busy === 1'b1)) begin
         n_err++;
         $display("FAIL basic_clear got mrst=%b a=%h b=%h busy=%b want 1,7,6,1",
                  mul_rst, mul_a, mul_b, busy);
      end
      stable = 1'b1;
      cyc = 1;
      while (!rsp_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (mul_a !== 32'd7 || mul_b !== 32'd6) stable = 1'b0;
      end
      n_vec++;
      if (stable !== 1'b1) begin
         n_err++;
         $display("FAIL basic_operand_hold got stable=%b want 1", stable);
      end
      n_vec++;
      if (cyc !== 36) begin
         n_err++;
         $display("FAIL basic_latency got cycle %0d want 36", cyc);
      end
      n_vec++;
      if ({rsp_id, rsp_data, rsp_err} !== {1'b0, 32'd42, 1'b0}) begin
         n_err++;
         $display("FAIL basic_rsp got id=%0d d=%0d err=%b want 0,42,0", rsp_id, rsp_data, rsp_err);
      end
      finish_rsp();
      n_vec++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_idle got busy=%b vld=%b want 0,0", busy, rsp_valid);
      end
   endtask

   task automatic test_fairness();
      int cyc;
      logic onehot_ok;
      logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [31:0] exp_dat [4] = '{32'd15, 32'd36, 32'd15, 32'd36};
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req_a = {32'd4, 32'd3};
      req_b = {32'd9, 32'd5};
      req_signed = 2'b00;
      req_upper  = 2'b00;
      req_valid  = 2'b11;
      onehot_ok  = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         n_vec++;
         if (req_ready !== exp_gnt[j]) begin
            n_err++;
            $display("FAIL rr_grant%0d got %b want %b", j, req_ready, exp_gnt[j]);
         end
         cyc = 0;
         while (!rsp_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if ($countones(req_ready) > 1) onehot_ok = 1'b0;
         end
         n_vec++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_dat[j] || rsp_id !== exp_gnt[j][1]) begin
            n_err++;
            $display("FAIL rr_rsp%0d got vld=%b id=%0d d=%0d want 1,%0d,%0d",
                     j, rsp_valid, rsp_id, rsp_data, exp_gnt[j][1], exp_dat[j]);
         end
         finish_rsp();
      end
      req_valid = 2'b00;
      n_vec++;
      if (onehot_ok !== 1'b1) begin
         n_err++;
         $display("FAIL rr_onehot got ok=%b want 1", onehot_ok);
      end
   endtask

   task automatic test_upper();
      int cyc;
      issue(1, 32'h8000_0000, 32'd2, 1'b0, 1'b1);
      wait_rsp(100, cyc);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b1, 32'h0000_0001, 1'b0}) begin
         n_err++;
         $display("FAIL upper_unsigned got vld=%b id=%0d d=%h err=%b want 1,1,00000001,0",
                  rsp_valid, rsp_id, rsp_data, rsp_err);
      end
      finish_rsp();
      issue(0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
      wait_rsp(100, cyc);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'hFFFF_FFFF}) begin
         n_err++;
         $display("FAIL upper_signed got vld=%b id=%0d d=%h want 1,0,ffffffff",
                  rsp_valid, rsp_id, rsp_data);
      end
      finish_rsp();
   endtask

   task automatic test_timeout();
      int cyc;
      m_hold_low = 1'b1;
      issue(0, 32'd2, 32'd3, 1'b0, 1'b0);
      wait_rsp(100, cyc);
      n_vec++;
      if (rsp_valid !== 1'b1 || cyc !== 43) begin
         n_err++;
         $display("FAIL timeout_latency got vld=%b cycle %0d want 1,43", rsp_valid, cyc);
      end
      n_vec++;
      if (rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
         n_err++;
         $display("FAIL timeout_rsp got err=%b d=%h want 1,0", rsp_err, rsp_data);
      end
      finish_rsp();
      m_hold_low = 1'b0;
   endtask

   task automatic test_backpressure();
      int cyc;
      issue(0, 32'd11, 32'd13, 1'b0, 1'b0);
      wait_rsp(100, cyc);
      req_a[63:32] = 32'd1; req_b[63:32] = 32'd1;
      req_valid[1] = 1'b1;
      for (int j = 0; j < 5; j++) begin
         n_vec++;
         if ({rsp_valid, rsp_data, req_ready} !== {1'b1, 32'd143, 2'b00}) begin
            n_err++;
            $display("FAIL bp_hold%0d got vld=%b d=%0d rdy=%b want 1,143,00",
                     j, rsp_valid, rsp_data, req_ready);
         end
         @(negedge clk);
      end
      finish_rsp();
      n_vec++;
      if ({busy, rsp_valid, req_ready} !== 4'b0010) begin
         n_err++;
         $display("FAIL bp_idle got busy=%b vld=%b rdy=%b want 0,0,10", busy, rsp_valid, req_ready);
      end
      req_valid[1] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_midjob();
      int cyc;
      logic seen;
      issue(0, 32'd5, 32'd5, 1'b0, 1'b0);
      repeat (11) @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if (mul_rst !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_assert got mrst=%b busy=%b want 1,1", mul_rst, busy);
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_idle got busy=%b vld=%b want 0,0", busy, rsp_valid);
      end
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_no_rsp got seen=%b want 0", seen);
      end
      issue(1, 32'd9, 32'd9, 1'b0, 1'b0);
      wait_rsp(100, cyc);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b1, 32'd81, 1'b0}) begin
         n_err++;
         $display("FAIL midrst_next got vld=%b id=%0d d=%0d err=%b want 1,1,81,0",
                  rsp_valid, rsp_id, rsp_data, rsp_err);
      end
      finish_rsp();
   endtask

   task automatic test_zero_operand();
      int cyc;
      logic pulsed;
      req_a[31:0] = 32'd12345; req_b[31:0] = 32'd0;
      req_signed[0] = 1'b0; req_upper[0] = 1'b0;
      req_valid[0] = 1'b1;
      @(negedge clk);
      req_valid[0] = 1'b0;
      pulsed = mul_rst;
      cyc = 1;
      while (!rsp_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (mul_rst) pulsed = 1'b1;
      end
`ifdef MUL_SCHED_ZERO_BYPASS_EN
      n_vec++;
      if (cyc !== 1 || pulsed !== 1'b0) begin
         n_err++;
         $display("FAIL zero_bypass got cycle %0d mrst_pulse=%b want 1,0", cyc, pulsed);
      end
`else
      n_vec++;
      if (cyc !== 36 || pulsed !== 1'b1) begin
         n_err++;
         $display("FAIL zero_full got cycle %0d mrst_pulse=%b want 36,1", cyc, pulsed);
      end
`endif
      n_vec++;
      if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 32'd0, 1'b0}) begin
         n_err++;
         $display("FAIL zero_rsp got vld=%b d=%h err=%b want 1,0,0", rsp_valid, rsp_data, rsp_err);
      end
      finish_rsp();
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 2'b00;
      req_a      = '0;
      req_b      = '0;
      req_signed = 2'b00;
      req_upper  = 2'b00;
      rsp_ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_fairness();
      test_upper();
      test_timeout();
      test_backpressure();
      test_reset_midjob();
      test_zero_operand();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
